// File: rtl/line_follow_controller_if.sv
// Sensor inputs, run request and motor/status outputs of the line-follow controller.
interface line_follow_controller_if;
    logic       enable;
    logic       sensorLeft;
    logic       sensorCenter;
    logic       sensorRight;
    logic [7:0] leftSpeed;
    logic [7:0] rightSpeed;
    logic [2:0] state;
    logic       lost;

    modport master (
        output enable, sensorLeft, sensorCenter, sensorRight,
        input  leftSpeed, rightSpeed, state, lost
    );

    modport slave (
        input  enable, sensorLeft, sensorCenter, sensorRight,
        output leftSpeed, rightSpeed, state, lost
    );
endinterface

// File: rtl/line_follow_controller.sv
// Three-sensor line follower: steers two wheel duties, searches when the line is
// lost for too long and halts if the search times out.
module line_follow_controller #(
    parameter logic [7:0]  SPEED_FULL     = 8'd200,
    parameter logic [7:0]  SPEED_TURN     = 8'd80,
    parameter logic [16:0] LOST_TIMEOUT   = 17'd50000,
    parameter logic [16:0] SEARCH_TIMEOUT = 17'd100000
) (
    input logic                     clk,
    input logic                     reset,
    line_follow_controller_if.slave bus
);
    localparam int unsigned CNT_W = 17;
    localparam logic [CNT_W-1:0] LOST_LAST   = LOST_TIMEOUT - CNT_W'(1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = SEARCH_TIMEOUT - CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FORWARD    = 3'd1,
        VEER_LEFT  = 3'd2,
        VEER_RIGHT = 3'd3,
        SEARCH     = 3'd4,
        HALT       = 3'd5
    } state_t;

    state_t           stateQ, stateD;
    logic [CNT_W-1:0] lostCountQ, lostCountD;
    logic [CNT_W-1:0] searchCountQ, searchCountD;
    logic             lastDirQ, lastDirD;
    logic [7:0]       leftSpeedQ, leftSpeedD;
    logic [7:0]       rightSpeedQ, rightSpeedD;
    logic             lostQ, lostD;
    logic [2:0]       pattern;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ       <= IDLE;
            lostCountQ   <= '0;
            searchCountQ <= '0;
            lastDirQ     <= 1'b0;
            leftSpeedQ   <= '0;
            rightSpeedQ  <= '0;
            lostQ        <= 1'b0;
        end else begin
            stateQ       <= stateD;
            lostCountQ   <= lostCountD;
            searchCountQ <= searchCountD;
            lastDirQ     <= lastDirD;
            leftSpeedQ   <= leftSpeedD;
            rightSpeedQ  <= rightSpeedD;
            lostQ        <= lostD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        lostCountD   = lostCountQ;
        searchCountD = searchCountQ;
        lastDirD     = lastDirQ;
        leftSpeedD   = '0;
        rightSpeedD  = '0;
        lostD        = 1'b0;
        pattern      = {bus.sensorLeft, bus.sensorCenter, bus.sensorRight};

        if (!bus.enable) begin
            stateD       = IDLE;
            lostCountD   = '0;
            searchCountD = '0;
        end else begin
            case (stateQ)
                IDLE: stateD = FORWARD;
                FORWARD, VEER_LEFT, VEER_RIGHT, SEARCH: begin
                    if (pattern == 3'b000) begin
                        // Line gone: time out tracking into search, then search into halt
                        if (stateQ == SEARCH) begin
                            if (searchCountQ == SEARCH_LAST) stateD = HALT;
                            searchCountD = satInc(searchCountQ);
                        end else if (lostCountQ == LOST_LAST) begin
                            stateD     = SEARCH;
                            lostCountD = '0;
                        end else begin
                            lostCountD = satInc(lostCountQ);
                        end
                    end else begin
                        lostCountD   = '0;
                        searchCountD = '0;
                        case (pattern)
                            3'b010, 3'b111: stateD = FORWARD;
                            3'b100, 3'b110: stateD = VEER_LEFT;
                            3'b001, 3'b011: stateD = VEER_RIGHT;
                            default:        stateD = stateQ;
                        endcase
                    end
                end
                HALT:    stateD = HALT;
                default: stateD = IDLE;
            endcase
        end

        if (stateD == VEER_LEFT)  lastDirD = 1'b0;
        if (stateD == VEER_RIGHT) lastDirD = 1'b1;

        // Outputs are registered alongside the state they describe
        case (stateD)
            FORWARD: begin
                leftSpeedD  = SPEED_FULL;
                rightSpeedD = SPEED_FULL;
            end
            VEER_LEFT: begin
                leftSpeedD  = SPEED_TURN;
                rightSpeedD = SPEED_FULL;
            end
            VEER_RIGHT: begin
                leftSpeedD  = SPEED_FULL;
                rightSpeedD = SPEED_TURN;
            end
            SEARCH: begin
                leftSpeedD  = lastDirD ? SPEED_TURN : 8'd0;
                rightSpeedD = lastDirD ? 8'd0 : SPEED_TURN;
            end
            HALT:    lostD = 1'b1;
            default: ;
        endcase
    end

    assign bus.state      = stateQ;
    assign bus.leftSpeed  = leftSpeedQ;
    assign bus.rightSpeed = rightSpeedQ;
    assign bus.lost       = lostQ;
endmodule

// File: tb/tb_line_follow_controller.sv
// Directed bench for line_follow_controller with short timeouts (lost 4, search 8).
module tb_line_follow_controller;
    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    line_follow_controller_if bus ();

    line_follow_controller #(
        .SPEED_FULL    (8'd200),
        .SPEED_TURN    (8'd80),
        .LOST_TIMEOUT  (17'd4),
        .SEARCH_TIMEOUT(17'd8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Apply one sensor pattern for one clock, then sample just after the edge
    task automatic step(input logic en, input logic [2:0] pat);
        @(negedge clk);
        bus.enable       = en;
        bus.sensorLeft   = pat[2];
        bus.sensorCenter = pat[1];
        bus.sensorRight  = pat[0];
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input int st, input int ls, input int rs, input int lo);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".left"},  32'(bus.leftSpeed), 32'(ls));
        check({tag, ".right"}, 32'(bus.rightSpeed), 32'(rs));
        check({tag, ".lost"},  32'(bus.lost), 32'(lo));
    endtask

    initial begin
        assertCount      = 0;
        failCount        = 0;
        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.sensorLeft   = 1'b0;
        bus.sensorCenter = 1'b1;
        bus.sensorRight  = 1'b0;

        step(1'b1, 3'b010);
        expectOut("reset", 0, 0, 0, 0);
        check("reset.lostCount", 32'(dut.lostCountQ), 32'd0);
        check("reset.lastDir", 32'(dut.lastDirQ), 32'd0);

        reset = 1'b0;
        step(1'b1, 3'b010);
        expectOut("start.fwd", 1, 200, 200, 0);

        step(1'b1, 3'b100);
        expectOut("veerL", 2, 80, 200, 0);
        step(1'b1, 3'b011);
        expectOut("veerR", 3, 200, 80, 0);
        check("veerR.lastDir", 32'(dut.lastDirQ), 32'd1);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b000);
            expectOut($sformatf("lostHold%0d", i), 3, 200, 80, 0);
        end
        check("lostHold.count", 32'(dut.lostCountQ), 32'd3);
        step(1'b1, 3'b000);
        expectOut("searchR", 4, 80, 0, 0);
        check("searchR.lostCount", 32'(dut.lostCountQ), 32'd0);
        step(1'b1, 3'b010);
        expectOut("recover", 1, 200, 200, 0);
        check("recover.lostCount", 32'(dut.lostCountQ), 32'd0);
        check("recover.searchCount", 32'(dut.searchCountQ), 32'd0);

        // Steer left then straight so the search turns toward the left
        step(1'b1, 3'b100);
        step(1'b1, 3'b010);
        expectOut("fwdL", 1, 200, 200, 0);
        check("fwdL.lastDir", 32'(dut.lastDirQ), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000);
        expectOut("preSearch", 1, 200, 200, 0);
        step(1'b1, 3'b000);
        expectOut("searchL", 4, 0, 80, 0);
        for (int i = 0; i < 7; i++) step(1'b1, 3'b000);
        expectOut("searchEnd", 4, 0, 80, 0);
        check("searchEnd.count", 32'(dut.searchCountQ), 32'd7);
        step(1'b1, 3'b000);
        expectOut("halt", 5, 0, 0, 1);
        step(1'b1, 3'b010);
        expectOut("haltHold", 5, 0, 0, 1);

        step(1'b0, 3'b010);
        expectOut("haltIdle", 0, 0, 0, 0);
        step(1'b1, 3'b010);
        expectOut("restart", 1, 200, 200, 0);

        step(1'b1, 3'b110);
        expectOut("veerL2", 2, 80, 200, 0);
        step(1'b1, 3'b101);
        expectOut("hold101", 2, 80, 200, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 3'b000);
        expectOut("search2", 4, 0, 80, 0);
        check("search2.count", 32'(dut.searchCountQ), 32'd2);
        reset = 1'b1;
        step(1'b1, 3'b000);
        expectOut("midReset", 0, 0, 0, 0);
        check("midReset.searchCount", 32'(dut.searchCountQ), 32'd0);
        check("midReset.lostCount", 32'(dut.lostCountQ), 32'd0);
        reset = 1'b0;
        step(1'b1, 3'b000);
        expectOut("postReset", 1, 200, 200, 0);

        step(1'b1, 3'b001);
        expectOut("veerR2", 3, 200, 80, 0);
        step(1'b1, 3'b101);
        expectOut("hold101R", 3, 200, 80, 0);
        step(1'b1, 3'b111);
        expectOut("fwd111", 1, 200, 200, 0);
        step(1'b0, 3'b111);
        expectOut("disable", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
